// File: rtl/epd_line_timing.sv
// Panel scan sequencer for a parallel e-paper interface.
// Walks one full frame per accepted start request, advancing one step per tick pulse,
// and drives the source- and gate-driver control lines plus the pixel fetch indices.
// All outputs are registered; between ticks everything holds.

module epd_line_timing #(
  parameter int unsigned ColsBytes   = 200,
  parameter int unsigned Rows        = 600,
  parameter int unsigned CkvLowTicks = 2,
  localparam int unsigned RowW = (Rows > 1) ? $clog2(Rows) : 1,
  localparam int unsigned ColW = (ColsBytes > 1) ? $clog2(ColsBytes) : 1,
  localparam int unsigned CntW = (CkvLowTicks > 1) ? $clog2(CkvLowTicks) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            tick_i,
  input  logic            start_i,
  input  logic [7:0]      pixel_data_i,
  output logic [RowW-1:0] row_idx_o,
  output logic [ColW-1:0] byte_idx_o,
  output logic [7:0]      epd_data_o,
  output logic            epd_cl_o,
  output logic            epd_sph_o,
  output logic            epd_le_o,
  output logic            epd_ckv_o,
  output logic            epd_spv_o,
  output logic            epd_gmode_o,
  output logic            epd_oe_o,
  output logic            busy_o,
  output logic            done_o
);

  // The accepting tick in idle performs the first frame-start step itself, so the
  // remaining frame-start steps are the four states below.
  typedef enum logic [3:0] {
    StIdle,
    StFs1,
    StFs2,
    StFs3,
    StFs4,
    StSph,
    StDataLo,
    StDataHi,
    StLatch,
    StFend
  } state_e;

  localparam logic [RowW-1:0] RowLast = RowW'(Rows - 1);
  localparam logic [ColW-1:0] ColLast = ColW'(ColsBytes - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CkvLowTicks - 1);

  state_e          state_q;
  logic            pending_q;
  logic [CntW-1:0] lat_cnt_q;
  logic [RowW-1:0] row_idx_q;
  logic [ColW-1:0] byte_idx_q;
  logic [7:0]      epd_data_q;
  logic            epd_cl_q;
  logic            epd_sph_q;
  logic            epd_le_q;
  logic            epd_ckv_q;
  logic            epd_spv_q;
  logic            epd_gmode_q;
  logic            epd_oe_q;
  logic            busy_q;
  logic            done_q;

  logic lat_first;
  logic lat_last;

  assign lat_first = (lat_cnt_q == '0);
  assign lat_last  = (lat_cnt_q == CntLast);

  // Sequencer: start capture every clock, state steps only on tick clocks.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      pending_q   <= 1'b0;
      lat_cnt_q   <= '0;
      row_idx_q   <= '0;
      byte_idx_q  <= '0;
      epd_data_q  <= 8'h00;
      epd_cl_q    <= 1'b0;
      epd_sph_q   <= 1'b1;
      epd_le_q    <= 1'b0;
      epd_ckv_q   <= 1'b0;
      epd_spv_q   <= 1'b1;
      epd_gmode_q <= 1'b0;
      epd_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // A request is only taken while idle and not already pending; otherwise dropped.
      if (state_q == StIdle && !pending_q && start_i) begin
        pending_q <= 1'b1;
        busy_q    <= 1'b1;
      end

      if (tick_i) begin
        unique case (state_q)
          StIdle: begin
            if (pending_q) begin
              pending_q   <= 1'b0;
              epd_oe_q    <= 1'b1;
              epd_gmode_q <= 1'b1;
              epd_spv_q   <= 1'b1;
              epd_ckv_q   <= 1'b1;
              state_q     <= StFs1;
            end
          end
          StFs1: begin
            epd_spv_q <= 1'b0;
            state_q   <= StFs2;
          end
          StFs2: begin
            epd_ckv_q <= 1'b0;
            state_q   <= StFs3;
          end
          StFs3: begin
            epd_ckv_q <= 1'b1;
            state_q   <= StFs4;
          end
          StFs4: begin
            epd_spv_q <= 1'b1;
            state_q   <= StSph;
          end
          StSph: begin
            // Also closes a single-tick latch phase: drop LE, release CKV.
            epd_sph_q  <= 1'b0;
            epd_le_q   <= 1'b0;
            epd_ckv_q  <= 1'b1;
            byte_idx_q <= '0;
            state_q    <= StDataLo;
          end
          StDataLo: begin
            epd_data_q <= pixel_data_i;
            epd_cl_q   <= 1'b0;
            state_q    <= StDataHi;
          end
          StDataHi: begin
            epd_cl_q <= 1'b1;
            if (byte_idx_q == ColLast) begin
              state_q <= StLatch;
            end else begin
              byte_idx_q <= byte_idx_q + ColW'(1);
              state_q    <= StDataLo;
            end
          end
          StLatch: begin
            if (lat_first) begin
              epd_sph_q <= 1'b1;
              epd_le_q  <= 1'b1;
              epd_ckv_q <= 1'b0;
              epd_cl_q  <= 1'b0;
            end else begin
              epd_le_q <= 1'b0;
            end
            // With a one-tick latch the CKV release happens in the following state.
            if (lat_last && !lat_first) begin
              epd_ckv_q <= 1'b1;
            end
            if (lat_last) begin
              lat_cnt_q <= '0;
              if (row_idx_q == RowLast) begin
                state_q <= StFend;
              end else begin
                row_idx_q <= row_idx_q + RowW'(1);
                state_q   <= StSph;
              end
            end else begin
              lat_cnt_q <= lat_cnt_q + CntW'(1);
            end
          end
          StFend: begin
            epd_ckv_q   <= 1'b0;
            epd_le_q    <= 1'b0;
            epd_oe_q    <= 1'b0;
            epd_gmode_q <= 1'b0;
            epd_data_q  <= 8'h00;
            row_idx_q   <= '0;
            byte_idx_q  <= '0;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign row_idx_o   = row_idx_q;
  assign byte_idx_o  = byte_idx_q;
  assign epd_data_o  = epd_data_q;
  assign epd_cl_o    = epd_cl_q;
  assign epd_sph_o   = epd_sph_q;
  assign epd_le_o    = epd_le_q;
  assign epd_ckv_o   = epd_ckv_q;
  assign epd_spv_o   = epd_spv_q;
  assign epd_gmode_o = epd_gmode_q;
  assign epd_oe_o    = epd_oe_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_epd_line_timing.sv
// Bench for epd_line_timing: a 4-byte x 3-row panel with a two-tick latch (dut_a) and
// the same panel with a one-tick latch (dut_b). Captured source bytes are scored against
// an expected-byte queue filled when each frame is requested.

module tb_epd_line_timing;

  localparam int unsigned Cols = 4;
  localparam int unsigned NRow = 3;
  localparam logic [20:0] RstVec = {9'b010010000, 12'h000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic tick = 1'b0;
  logic tick_en;
  int   div = 0;
  logic start_a, start_b;
  logic [7:0] pix_a, pix_b;

  logic [1:0] row_a, byte_a, row_b, byte_b;
  logic [7:0] data_a, data_b;
  logic cl_a, sph_a, le_a, ckv_a, spv_a, gmode_a, oe_a, busy_a, done_a;
  logic cl_b, sph_b, le_b, ckv_b, spv_b, gmode_b, oe_b, busy_b, done_b;

  epd_line_timing #(.ColsBytes(Cols), .Rows(NRow), .CkvLowTicks(2)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .start_i(start_a), .pixel_data_i(pix_a),
    .row_idx_o(row_a), .byte_idx_o(byte_a), .epd_data_o(data_a), .epd_cl_o(cl_a),
    .epd_sph_o(sph_a), .epd_le_o(le_a), .epd_ckv_o(ckv_a), .epd_spv_o(spv_a),
    .epd_gmode_o(gmode_a), .epd_oe_o(oe_a), .busy_o(busy_a), .done_o(done_a)
  );

  epd_line_timing #(.ColsBytes(Cols), .Rows(NRow), .CkvLowTicks(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .start_i(start_b), .pixel_data_i(pix_b),
    .row_idx_o(row_b), .byte_idx_o(byte_b), .epd_data_o(data_b), .epd_cl_o(cl_b),
    .epd_sph_o(sph_b), .epd_le_o(le_b), .epd_ckv_o(ckv_b), .epd_spv_o(spv_b),
    .epd_gmode_o(gmode_b), .epd_oe_o(oe_b), .busy_o(busy_b), .done_o(done_b)
  );

  // Row buffer model with one clock of read latency: byte = {row, col} nibbles.
  always @(posedge clk) begin
    pix_a <= {2'b00, row_a, 2'b00, byte_a};
    pix_b <= {2'b00, row_b, 2'b00, byte_b};
  end

  // Tick every third clock while enabled.
  always @(posedge clk) begin
    #1;
    if (!tick_en) begin
      tick = 1'b0;
      div  = 0;
    end else if (div == 2) begin
      tick = 1'b1;
      div  = 0;
    end else begin
      tick = 1'b0;
      div  = div + 1;
    end
  end

  wire [20:0] vec_a = {cl_a, sph_a, le_a, ckv_a, spv_a, gmode_a, oe_a, busy_a, done_a,
                       data_a, row_a, byte_a};
  wire [20:0] vec_b = {cl_b, sph_b, le_b, ckv_b, spv_b, gmode_b, oe_b, busy_b, done_b,
                       data_b, row_b, byte_b};

  logic sel;
  wire       o_cl   = sel ? cl_b : cl_a;
  wire       o_le   = sel ? le_b : le_a;
  wire       o_ckv  = sel ? ckv_b : ckv_a;
  wire       o_spv  = sel ? spv_b : spv_a;
  wire       o_busy = sel ? busy_b : busy_a;
  wire       o_done = sel ? done_b : done_a;
  wire [7:0] o_data = sel ? data_b : data_a;
  wire [1:0] o_row  = sel ? row_b : row_a;
  wire [1:0] o_byte = sel ? byte_b : byte_a;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Observation state, written only from the main initial process.
  bit p_cl, p_le, p_ckv, p_spv, p_busy, spv_armed, seen_le, busy_at_done;
  int n_cl, n_le, n_ckv_gate, n_spv_fall, n_done, n_busy_rise;
  int spv_run, ckv_run, le_run, tick_run, gap_run, frame_ticks, max_row, max_byte;
  logic [7:0] cap_q[$];
  logic [7:0] exp_q[$];
  int gaps_q[$];
  int le_hi_q[$];
  int ckv_lo_q[$];
  int spv_lo_q[$];

  task automatic sync_mon();
    #1;
    p_cl = o_cl; p_le = o_le; p_ckv = o_ckv; p_spv = o_spv; p_busy = o_busy;
    spv_armed = 0; seen_le = 0; busy_at_done = 1;
    n_cl = 0; n_le = 0; n_ckv_gate = 0; n_spv_fall = 0; n_done = 0; n_busy_rise = 0;
    spv_run = 0; ckv_run = 0; le_run = 0; tick_run = 0; gap_run = 0; frame_ticks = -1;
    max_row = 0; max_byte = 0;
    cap_q.delete(); gaps_q.delete(); le_hi_q.delete(); ckv_lo_q.delete(); spv_lo_q.delete();
  endtask

  // Advance to the next falling edge and record edges of the selected DUT.
  task automatic step();
    @(negedge clk);
    if (o_cl && !p_cl) begin
      n_cl++;
      cap_q.push_back(o_data);
    end
    if (o_le && !p_le) begin
      n_le++;
      if (seen_le) gaps_q.push_back(gap_run);
      seen_le = 1;
      gap_run = 0;
      le_run  = 0;
    end
    if (!o_le && p_le) le_hi_q.push_back(le_run);
    if (o_le) le_run++;
    if (tick) gap_run++;
    if (!o_ckv && p_ckv) ckv_run = 0;
    if (o_ckv && !p_ckv && spv_armed) begin
      n_ckv_gate++;
      ckv_lo_q.push_back(ckv_run);
    end
    if (!o_ckv && tick) ckv_run++;
    if (!o_spv && p_spv) begin
      n_spv_fall++;
      spv_armed = 1;
      spv_run   = 0;
    end
    if (o_spv && !p_spv) spv_lo_q.push_back(spv_run);
    if (!o_spv && tick) spv_run++;
    if (o_busy && !p_busy) n_busy_rise++;
    if (o_done) begin
      n_done++;
      frame_ticks  = tick_run;
      busy_at_done = o_busy;
    end
    if (!o_busy) tick_run = 0;
    else if (tick) tick_run++;
    if (int'(o_row) > max_row) max_row = int'(o_row);
    if (int'(o_byte) > max_byte) max_byte = int'(o_byte);
    p_cl = o_cl; p_le = o_le; p_ckv = o_ckv; p_spv = o_spv; p_busy = o_busy;
  endtask

  task automatic set_start(input bit s, input logic v);
    if (s) start_b = v;
    else start_a = v;
  endtask

  task automatic push_frame_bytes();
    exp_q.delete();
    for (int r = 0; r < int'(NRow); r++)
      for (int b = 0; b < int'(Cols); b++) exp_q.push_back(8'(r * 16 + b));
  endtask

  // Request a frame and run until done; optionally re-pulse start at step mid_at.
  task automatic run_frame(input bit s, input int budget, input int mid_at, output bit to);
    int k;
    sel = s;
    sync_mon();
    set_start(s, 1'b1);
    step();
    set_start(s, 1'b0);
    k = 0;
    while (n_done == 0 && k < budget) begin
      set_start(s, (k == mid_at) ? 1'b1 : 1'b0);
      step();
      k++;
    end
    set_start(s, 1'b0);
    to = (n_done == 0);
  endtask

  task automatic test_reset();
    chk_cnt++;
    if (vec_a !== RstVec) $display("FAIL reset_a: got %h want %h", vec_a, RstVec);
    else pass_cnt++;
    chk_cnt++;
    if (vec_b !== RstVec) $display("FAIL reset_b: got %h want %h", vec_b, RstVec);
    else pass_cnt++;
    rst_n = 1'b1;
    tick_en = 1'b1;
    repeat (10) @(negedge clk);
    chk_cnt++;
    if (vec_a !== RstVec) $display("FAIL idle_hold_a: got %h want %h", vec_a, RstVec);
    else pass_cnt++;
  endtask

  task automatic test_full_frame();
    bit to;
    push_frame_bytes();
    run_frame(1'b0, 400, -1, to);
    repeat (3) step();
    chk_cnt++;
    if (to) $display("FAIL frame_timeout: got no done want done");
    else pass_cnt++;
    chk_cnt++;
    if (frame_ticks != 39) $display("FAIL frame_ticks: got %0d want 39", frame_ticks);
    else pass_cnt++;
    chk_cnt++;
    if (n_cl != 12) $display("FAIL cl_rises: got %0d want 12", n_cl);
    else pass_cnt++;
    chk_cnt++;
    if (n_le != 3) $display("FAIL le_pulses: got %0d want 3", n_le);
    else pass_cnt++;
    chk_cnt++;
    if (n_ckv_gate != 4) $display("FAIL ckv_rises: got %0d want 4", n_ckv_gate);
    else pass_cnt++;
    chk_cnt++;
    if (n_spv_fall != 1 || spv_lo_q.size() != 1 || spv_lo_q[0] != 3)
      $display("FAIL spv_pulse: got falls %0d len %0d want 1 and 3", n_spv_fall,
               (spv_lo_q.size() > 0) ? spv_lo_q[0] : -1);
    else pass_cnt++;
    chk_cnt++;
    if (n_done != 1 || busy_at_done !== 1'b0)
      $display("FAIL done_pulse: got clocks %0d busy %0b want 1 and 0", n_done, busy_at_done);
    else pass_cnt++;
    chk_cnt++;
    if (gaps_q.size() != 2 || gaps_q[0] != 11 || gaps_q[1] != 11)
      $display("FAIL row_ticks: got %0d gaps first %0d want 2 of 11", gaps_q.size(),
               (gaps_q.size() > 0) ? gaps_q[0] : -1);
    else pass_cnt++;
    chk_cnt++;
    if (max_row != 2 || max_byte != 3)
      $display("FAIL index_range: got row %0d byte %0d want 2 and 3", max_row, max_byte);
    else pass_cnt++;
    chk_cnt++;
    if (vec_a !== RstVec) $display("FAIL after_frame: got %h want %h", vec_a, RstVec);
    else pass_cnt++;
    chk_cnt++;
    if (cap_q.size() != exp_q.size())
      $display("FAIL byte_count: got %0d want %0d", cap_q.size(), exp_q.size());
    else pass_cnt++;
    while (exp_q.size() > 0 && cap_q.size() > 0) begin
      logic [7:0] e, c;
      e = exp_q.pop_front();
      c = cap_q.pop_front();
      chk_cnt++;
      if (c !== e) $display("FAIL data_byte: got %h want %h", c, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_start_while_busy();
    bit to;
    run_frame(1'b0, 400, 40, to);
    repeat (60) step();
    chk_cnt++;
    if (to || n_done != 1) $display("FAIL busy_start_done: got %0d want 1", n_done);
    else pass_cnt++;
    chk_cnt++;
    if (n_busy_rise != 1 || busy_a !== 1'b0)
      $display("FAIL busy_start_idle: got rises %0d busy %0b want 1 and 0", n_busy_rise,
               busy_a);
    else pass_cnt++;
    chk_cnt++;
    if (frame_ticks != 39) $display("FAIL busy_start_ticks: got %0d want 39", frame_ticks);
    else pass_cnt++;
  endtask

  task automatic test_tick_gating();
    int k;
    bit changed;
    logic [20:0] snap;
    sel = 1'b0;
    sync_mon();
    push_frame_bytes();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    k = 0;
    while (!(cl_a && !tick && row_a == 2'd1) && k < 300) begin
      step();
      k++;
    end
    chk_cnt++;
    if (!(cl_a && row_a == 2'd1)) $display("FAIL gate_reach: got cl %0b want 1", cl_a);
    else pass_cnt++;
    tick_en = 1'b0;
    snap = vec_a;
    changed = 0;
    repeat (50) begin
      step();
      if (vec_a !== snap) changed = 1;
    end
    chk_cnt++;
    if (changed) $display("FAIL gate_hold: got %h want %h", vec_a, snap);
    else pass_cnt++;
    tick_en = 1'b1;
    k = 0;
    while (cl_a && k < 10) begin
      step();
      k++;
    end
    chk_cnt++;
    if (cl_a !== 1'b0) $display("FAIL gate_resume: got cl %0b want 0", cl_a);
    else pass_cnt++;
    k = 0;
    while (n_done == 0 && k < 400) begin
      step();
      k++;
    end
    chk_cnt++;
    if (n_done != 1 || frame_ticks != 39)
      $display("FAIL gate_frame: got done %0d ticks %0d want 1 and 39", n_done, frame_ticks);
    else pass_cnt++;
    chk_cnt++;
    if (cap_q.size() != exp_q.size())
      $display("FAIL gate_byte_count: got %0d want %0d", cap_q.size(), exp_q.size());
    else pass_cnt++;
    while (exp_q.size() > 0 && cap_q.size() > 0) begin
      logic [7:0] e, c;
      e = exp_q.pop_front();
      c = cap_q.pop_front();
      chk_cnt++;
      if (c !== e) $display("FAIL gate_data_byte: got %h want %h", c, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_row();
    int k;
    bit to;
    sel = 1'b0;
    sync_mon();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    k = 0;
    while (!(row_a == 2'd1 && byte_a == 2'd1 && !cl_a && !sph_a) && k < 300) begin
      step();
      k++;
    end
    chk_cnt++;
    if (!(row_a == 2'd1 && busy_a)) $display("FAIL midrow_reach: got row %0d want 1", row_a);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (vec_a !== RstVec) $display("FAIL midrow_reset: got %h want %h", vec_a, RstVec);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sync_mon();
    repeat (60) step();
    chk_cnt++;
    if (n_done != 0 || busy_a !== 1'b0)
      $display("FAIL midrow_nodone: got done %0d busy %0b want 0 and 0", n_done, busy_a);
    else pass_cnt++;
    run_frame(1'b0, 400, -1, to);
    chk_cnt++;
    if (to || n_done != 1 || frame_ticks != 39)
      $display("FAIL midrow_restart: got done %0d ticks %0d want 1 and 39", n_done,
               frame_ticks);
    else pass_cnt++;
  endtask

  task automatic test_ckv_low_one();
    bit to;
    run_frame(1'b1, 400, -1, to);
    repeat (3) step();
    chk_cnt++;
    if (to || frame_ticks != 36)
      $display("FAIL short_frame_ticks: got %0d want 36", frame_ticks);
    else pass_cnt++;
    chk_cnt++;
    if (gaps_q.size() != 2) $display("FAIL short_gap_count: got %0d want 2", gaps_q.size());
    else pass_cnt++;
    foreach (gaps_q[i]) begin
      chk_cnt++;
      if (gaps_q[i] != 10) $display("FAIL short_row_ticks: got %0d want 10", gaps_q[i]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (le_hi_q.size() != 3) $display("FAIL short_le_count: got %0d want 3", le_hi_q.size());
    else pass_cnt++;
    foreach (le_hi_q[i]) begin
      chk_cnt++;
      if (le_hi_q[i] != 3) $display("FAIL short_le_width: got %0d clk want 3", le_hi_q[i]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (ckv_lo_q.size() != 3) $display("FAIL short_ckv_count: got %0d want 3", ckv_lo_q.size());
    else pass_cnt++;
    foreach (ckv_lo_q[i]) begin
      chk_cnt++;
      if (ckv_lo_q[i] != 1) $display("FAIL short_ckv_low: got %0d ticks want 1", ckv_lo_q[i]);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    tick_en = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    sel     = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_full_frame();
    test_start_while_busy();
    test_tick_gating();
    test_reset_mid_row();
    test_ckv_low_one();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/epd_line_timing.md
# epd_line_timing

- Panel scan sequencer for the parallel e-paper interface.
- Consumes the single-cycle `tick` pulses produced by the clock divider and positive-edge detector, one state step per tick.
- Produces the source-driver signals (`epdCl`, `epdSph`, `epdLe`, `epdData`) and the gate-driver signals (`epdCkv`, `epdSpv`, `epdGmode`, `epdOe`) for one full frame per `start` request.
- Pixel bytes are fetched from an external frame/row buffer by row/byte index.

## Interface

Parameters:
- `COLS_BYTES`, 200: bytes per row (4 px/byte).
- `ROWS`, 600: rows per frame.
- `CKV_LOW_TICKS`, 2: ticks `epdCkv` is held low per row (≥1).

Ports:
- `clock` in 1: system clock; all logic clocked on rising edge.
- `resetN` in 1: asynchronous, active-low reset.
- `tick` in 1: one-clock enable pulse. Consecutive ticks are ≥2 clocks apart.
- `start` in 1: frame request, sampled every clock.
- `pixelData` in 8: byte at (`rowIdx`, `byteIdx`). Valid by the clock after the indices change.
- `rowIdx` out $clog2(ROWS): current row.
- `byteIdx` out $clog2(COLS_BYTES): current byte in row.
- `epdData` out 8: source data bus.
- `epdCl` out 1: source clock; data is taken on the rising edge.
- `epdSph` out 1: horizontal start pulse, active low.
- `epdLe` out 1: source latch enable, active high.
- `epdCkv` out 1: gate clock.
- `epdSpv` out 1: vertical start pulse, active low.
- `epdGmode` out 1: gate mode.
- `epdOe` out 1: source output enable.
- `busy` out 1: high from frame acceptance to return to IDLE.
- `done` out 1: one-clock pulse at frame end.

## Operation

- **Reset values:** `epdCl`=0, `epdSph`=1, `epdLe`=0, `epdCkv`=0, `epdSpv`=1, `epdGmode`=0, `epdOe`=0, `epdData`=0, `rowIdx`=0, `byteIdx`=0, `busy`=0, `done`=0; state IDLE, pending flag cleared.
- All outputs are registered. State advances only on clocks where `tick`=1; between ticks everything holds.
- **Start handling:** `start`=1 in IDLE sets a pending flag and `busy`=1 on that clock. `start` while busy is ignored (not queued).
- **IDLE:** on a tick with pending set, clear pending and enter FS0.
- **Frame-start sequence, one tick each:**
  - FS0: `epdOe`=1, `epdGmode`=1, `epdSpv`=1, `epdCkv`=1.
  - FS1: `epdSpv`=0.
  - FS2: `epdCkv`=0.
  - FS3: `epdCkv`=1.
  - FS4: `epdSpv`=1.
  - Then go to SPH.
- **SPH:** `epdSph`=0, `byteIdx`=0. Next state is DATA_LO.
- **DATA_LO:** `epdData`=`pixelData`, `epdCl`=0.
- **DATA_HI:** `epdCl`=1.
  - If `byteIdx`=COLS_BYTES-1, go to LATCH.
  - Otherwise increment `byteIdx` and go to DATA_LO.
- **LATCH:** lasts CKV_LOW_TICKS ticks, counted by an internal counter.
  - First tick: `epdSph`=1, `epdLe`=1, `epdCkv`=0, `epdCl`=0.
  - Following ticks: `epdLe`=0, `epdCkv` stays 0.
  - On the tick that ends LATCH: `epdLe`=0, `epdCkv`=1.
  - If `rowIdx`=ROWS-1, go to FEND. Otherwise increment `rowIdx` and go to SPH.
  - With CKV_LOW_TICKS=1, the single LATCH tick sets `epdLe`=1 and `epdCkv`=0. The next state's tick then clears `epdLe` and sets `epdCkv`=1.
- **FEND (one tick):**
  - Set `epdCkv`=0, `epdOe`=0, `epdGmode`=0, `epdData`=0, `rowIdx`=0, `byteIdx`=0.
  - Pulse `done` for exactly one clock; `busy`=0 on the same clock.
  - Go to IDLE.
- **Wrap-around:** index counters never exceed their terminal counts. They are reset to 0 at SPH and FEND, not by rollover.
- **Reset mid-frame:** all outputs return immediately (asynchronously) to reset values. The frame is abandoned and no `done` is issued.

## Timing

- One byte takes 2 ticks.
- One row takes 1 + 2·COLS_BYTES + CKV_LOW_TICKS ticks.
- A frame from the first tick after acceptance to FEND takes 5 + ROWS·(1+2·COLS_BYTES+CKV_LOW_TICKS) + 1 ticks.
- `start` is accepted on the same clock it is seen. There is up to one tick period of latency before FS0.
- `pixelData` is sampled on the DATA_LO tick. The indices changed ≥1 tick (≥2 clocks) earlier, so there is a 1-clock read latency budget.
- `epdData` is stable for a full tick before and after each `epdCl` rising edge.
- `done` and `busy` falling occur on the FEND tick clock.

## Test plan

- **Full frame:** COLS_BYTES=4, ROWS=3, CKV_LOW_TICKS=2, tick every 3 clocks; pulse `start`.
  - Exactly 39 ticks to `done`.
  - 12 `epdCl` rising edges, 3 `epdLe` pulses, 4 `epdCkv` rising edges, 1 `epdSpv` low pulse of 3 ticks.
- **Data path:** `pixelData` = {rowIdx[3:0], byteIdx[3:0]}.
  - Bytes captured at `epdCl` rises are 0x00,0x01,0x02,0x03,0x10,…,0x23 in order.
- **Start while busy:** second `start` mid-frame.
  - Ignored; exactly one `done`; IDLE afterwards with `busy`=0.
- **Tick gating:** hold `tick` low for 50 clocks inside DATA_HI.
  - All outputs unchanged; sequence resumes on the next tick.
- **Reset mid-row:** assert `resetN`=0 during DATA_LO of row 1.
  - Outputs go to reset values within the same clock period.
  - No `done`; a new `start` then produces a full 39-tick frame.
- **CKV_LOW_TICKS=1:**
  - Each row is 10 ticks.
  - `epdLe` and `epdCkv`=0 are high/low for exactly one tick per row.
